cdc_hs_tx: RTL
==============

// Module: cdc_hs_tx
// PURPOSE
//  Source-domain end of a 2-phase (toggle) req/ack CDC handshake. Accepts one
//  BUS_WIDTH word per transfer, holds it stable on TX_DATA, toggles TX_REQ,
//  then waits for the far-domain ACK toggle (synchronized internally) before
//  accepting the next word. Pairs with a destination-side bit synchronizer/
//  receiver that samples TX_DATA once its synchronized REQ toggles.
// PARAMETERS
//  BUS_WIDTH   8   width of transferred word
//  NUM_STAGES  2   flop stages in the ACK_ASYNC synchronizer (legal >= 2)
//  TIMEOUT_CYC 0   WAIT_ACK cycles before ERR sets; 0 disables timeout
//  CNT_W       16  width of the timeout counter (must hold TIMEOUT_CYC)
// PORTS
//  CLK        in   1          source-domain clock, rising edge
//  RST        in   1          asynchronous, active-low reset
//  SRC_DATA   in   BUS_WIDTH  word to send, sampled on accept
//  SRC_VALID  in   1          word on SRC_DATA is valid
//  SRC_READY  out  1          block can accept a word (state IDLE)
//  TX_DATA    out  BUS_WIDTH  registered word, stable from REQ toggle to ACK
//  TX_REQ     out  1          request level; toggles once per transfer
//  ACK_ASYNC  in   1          ack toggle from destination domain (asynchronous)
//  DONE       out  1          1-cycle pulse: transfer acknowledged
//  ERR        out  1          sticky: ACK not seen within TIMEOUT_CYC cycles
//  ERR_CLR    in   1          synchronous clear of ERR
// BEHAVIOUR
//  - Reset (RST=0, async): state=IDLE, TX_DATA=0, TX_REQ=0, ack sync flops=0,
//    DONE=0, ERR=0, counter=0. SRC_READY=1 after reset release.
//  - ACK synchronizer: NUM_STAGES-flop shift chain on ACK_ASYNC; ack_s = last
//    stage. No logic between stages. ACK_ASYNC must be a flop output upstream.
//  - SRC_READY = (state==IDLE); combinational from state only.
//  - FSM states: IDLE, WAIT_ACK.
//    IDLE: SRC_VALID&&SRC_READY at edge N -> at N+1: TX_DATA<=SRC_DATA,
//      TX_REQ<=~TX_REQ, counter<=0, state<=WAIT_ACK. Else hold.
//    WAIT_ACK: if ack_s==TX_REQ -> state<=IDLE, DONE<=1 for one cycle.
//      Else counter increments, saturating at all-ones.
//  - SRC_READY low on the same cycle DONE is high? No: DONE and return to
//    IDLE occur on the same edge; SRC_READY=1 while DONE=1, so a new word may
//    be accepted on the DONE cycle (back-to-back transfers).
//  - TX_DATA changes only on accept; never while in WAIT_ACK.
//  - Minimum transfer period: 1 (accept) + round trip via far domain +
//    NUM_STAGES cycles of ack sync + 1 (compare) cycles.
//  - Timeout: if TIMEOUT_CYC!=0 and counter==TIMEOUT_CYC-1 in WAIT_ACK with no
//    ack -> ERR<=1. FSM keeps waiting (toggle protocol cannot be aborted).
//  - ERR_CLR=1 clears ERR next edge; a simultaneous timeout event wins (ERR=1).
//  - ACK toggle arriving while in IDLE (ack_s!=TX_REQ) is a protocol error:
//    ignored by FSM; no state change, no DONE.
//  - Reset mid-transfer: all state cleared immediately; destination side must
//    be reset in the same reset domain event, else levels may mismatch.
//  - SRC_VALID deasserting while SRC_READY=0 is permitted; nothing is lost.
// TESTING
//  - Reset: RST=0 mid-WAIT_ACK -> TX_REQ=0, TX_DATA=0, DONE=0, ERR=0,
//    SRC_READY=1 immediately.
//  - Single transfer (NUM_STAGES=2): send 0xA5, loop ACK_ASYNC=TX_REQ after 3
//    cycles -> TX_REQ 0->1 one cycle after accept, TX_DATA=0xA5 held, DONE
//    pulses exactly once, 3+2+1 cycles after TX_REQ toggle.
//  - Back-to-back: SRC_VALID held with 0x01,0x02,0x03 -> TX_REQ toggles 3
//    times, 3 DONE pulses, TX_DATA never changes in WAIT_ACK.
//  - Timeout (TIMEOUT_CYC=8): no ack -> ERR=1 after 8 WAIT cycles, SRC_READY
//    stays 0; later ack -> DONE pulses, ERR stays 1 until ERR_CLR.
//  - ERR_CLR coincident with timeout -> ERR=1; ERR_CLR next cycle -> ERR=0.
//  - Spurious ACK toggle in IDLE -> no DONE, state stays IDLE.

Source files
------------

// File: rtl/cdc_hs_tx.sv
// Source-domain side of a 2-phase (toggle) req/ack CDC handshake.
// A word is captured on accept and held on TX_DATA while TX_REQ is toggled.
// The next word is accepted only after the synchronized ACK level matches TX_REQ.
module cdc_hs_tx #(
    parameter int unsigned BUS_WIDTH   = 8,
    parameter int unsigned NUM_STAGES  = 2,
    parameter int unsigned TIMEOUT_CYC = 0,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] SRC_DATA,
    input  logic                 SRC_VALID,
    output logic                 SRC_READY,
    output logic [BUS_WIDTH-1:0] TX_DATA,
    output logic                 TX_REQ,
    input  logic                 ACK_ASYNC,
    output logic                 DONE,
    output logic                 ERR,
    input  logic                 ERR_CLR
);

    typedef enum logic [0:0] {
        StIdle,
        StWaitAck
    } state_e;

    localparam logic [CNT_W-1:0] CntMax    = '1;
    localparam logic [CNT_W-1:0] CntLast   = CNT_W'(TIMEOUT_CYC - 1);
    localparam bit               TimeoutEn = (TIMEOUT_CYC != 0);

    state_e                 state_q, state_d;
    logic [NUM_STAGES-1:0]  ack_sync_q;
    logic                   ack_s;
    logic [BUS_WIDTH-1:0]   data_q, data_d;
    logic                   req_q, req_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   timeout;

    // Plain shift chain so the first stage is the only flop seeing ACK_ASYNC.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[NUM_STAGES-2:0], ACK_ASYNC};
        end
    end

    assign ack_s = ack_sync_q[NUM_STAGES-1];

    // Handshake state, held word, request level, timeout counter and flags.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StIdle;
            data_q  <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            req_q   <= req_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: accept in idle, wait for matching ack level otherwise.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        timeout = 1'b0;
        unique case (state_q)
            StIdle: begin
                // An ack level change seen here is a protocol error and is ignored.
                if (SRC_VALID) begin
                    data_d  = SRC_DATA;
                    req_d   = ~req_q;
                    cnt_d   = '0;
                    state_d = StWaitAck;
                end
            end
            StWaitAck: begin
                if (ack_s == req_q) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    timeout = TimeoutEn && (cnt_q == CntLast);
                    if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Timeout wins over a coincident clear.
        if (timeout) begin
            err_d = 1'b1;
        end else if (ERR_CLR) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    assign SRC_READY = (state_q == StIdle);
    assign TX_DATA   = data_q;
    assign TX_REQ    = req_q;
    assign DONE      = done_q;
    assign ERR       = err_q;

endmodule
